// File: rtl/acqbuf_pkg.sv
// acqbuf_pkg: shared types and defaults for the acquisition buffer controller.
// Holds the transfer-request FSM state encoding, the default geometry
// constants and a saturating counter helper.
package acqbuf_pkg;

  // Default geometry
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DEPTH  = 512;
  localparam int DEF_THRESH = 256;

  // DSP transfer-request FSM
  typedef enum logic [1:0] {
    ARM  = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  // Increment an 8-bit event counter, holding at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/acqbuf_ram.sv
// acqbuf_ram: simple dual-port storage for the acquisition FIFO.
// Synchronous write port, registered read port. The read register is
// cleared by reset and by the soft clear so the bus sees 0 after either.
module acqbuf_ram
  import acqbuf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port: store one word per enabled cycle
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered output, held when no read is requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/acqbuf_ctrl.sv
// acqbuf_ctrl: acquisition FIFO controller with DSP burst-transfer request.
// Circular buffer (storage in acqbuf_ram) with exact occupancy count,
// sticky overflow/underflow flags and an ARM/REQ/XFER request FSM that
// raises xfer_irq whenever THRESH words are waiting.
// Optional build macro ACQBUF_OVF_CNT_EN adds ovf_cnt[7:0], a saturating
// count of dropped writes.
module acqbuf_ctrl
  import acqbuf_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int THRESH = DEF_THRESH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       datain,
  input  logic                   rd_strobe,
  output logic [WIDTH-1:0]       dataout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   xfer_irq,
  output logic                   overflow,
  output logic                   underflow
`ifdef ACQBUF_OVF_CNT_EN
  ,
  output logic [7:0]             ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
  localparam logic [CW-1:0] C_THRESH    = CW'(THRESH);
  localparam logic [CW-1:0] C_BURST_ONE = CW'(1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_overflow;
  logic          r_underflow;
  state_t        r_state;
  logic [CW-1:0] r_burst;
  logic          r_xfer_irq;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_wr_drop;
  logic          w_rd_miss;
  logic [CW-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_rdata;

  // A write is taken only with room; a read only with data. Clear wins.
  assign w_wr_acc  = wr_en & ~r_full & ~clr;
  assign w_rd_acc  = rd_strobe & ~r_empty & ~clr;
  assign w_wr_drop = wr_en & r_full & ~clr;
  assign w_rd_miss = rd_strobe & r_empty & ~clr;

  // Next occupancy: simultaneous accepted write and read cancel out
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy, status and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == C_DEPTH);
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_rd_miss) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Transfer-request FSM: ARM waits for a burst, REQ signals the DSP,
  // XFER counts down the remaining burst reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ARM;
      r_burst    <= '0;
      r_xfer_irq <= 1'b0;
    end else if (clr) begin
      r_state    <= ARM;
      r_burst    <= '0;
      r_xfer_irq <= 1'b0;
    end else begin
      case (r_state)
        ARM: begin
          if (r_count >= C_THRESH) begin
            r_state    <= REQ;
            r_burst    <= C_THRESH;
            r_xfer_irq <= 1'b1;
          end else begin
            r_xfer_irq <= 1'b0;
          end
        end
        REQ: begin
          if (w_rd_acc) begin
            r_burst    <= r_burst - 1'b1;
            r_xfer_irq <= 1'b0;
            if (r_burst == C_BURST_ONE) begin
              r_state <= ARM;
            end else begin
              r_state <= XFER;
            end
          end else begin
            r_xfer_irq <= 1'b1;
          end
        end
        XFER: begin
          r_xfer_irq <= 1'b0;
          if (w_rd_acc) begin
            r_burst <= r_burst - 1'b1;
            if (r_burst == C_BURST_ONE) begin
              r_state <= ARM;
            end else begin
              r_state <= XFER;
            end
          end
        end
        default: begin
          r_state    <= ARM;
          r_burst    <= '0;
          r_xfer_irq <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACQBUF_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  // Dropped-write counter, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_cnt <= 8'd0;
    end else if (clr) begin
      r_ovf_cnt <= 8'd0;
    end else if (w_wr_drop) begin
      r_ovf_cnt <= sat_inc8(r_ovf_cnt);
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  acqbuf_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .i_clr   (clr),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (datain),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign dataout   = w_rdata;
  assign count     = r_count;
  assign empty     = r_empty;
  assign full      = r_full;
  assign xfer_irq  = r_xfer_irq;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_acqbuf_ctrl.sv
// tb_acqbuf_ctrl: directed self-checking bench for acqbuf_ctrl (default
// WIDTH=16, DEPTH=512, THRESH=256). Optional ACQBUF_OVF_CNT_EN build also
// checks ovf_cnt.
module tb_acqbuf_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic        wr_en;
  logic [15:0] datain;
  logic        rd_strobe;
  logic [15:0] dataout;
  logic [9:0]  count;
  logic        empty;
  logic        full;
  logic        xfer_irq;
  logic        overflow;
  logic        underflow;
`ifdef ACQBUF_OVF_CNT_EN
  logic [7:0]  ovf_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  acqbuf_ctrl #(
    .WIDTH  (16),
    .DEPTH  (512),
    .THRESH (256)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .wr_en     (wr_en),
    .datain    (datain),
    .rd_strobe (rd_strobe),
    .dataout   (dataout),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .xfer_irq  (xfer_irq),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef ACQBUF_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".count"},     32'(count),     32'd0);
    check({tag, ".empty"},     32'(empty),     32'd1);
    check({tag, ".full"},      32'(full),      32'd0);
    check({tag, ".dataout"},   32'(dataout),   32'd0);
    check({tag, ".xfer_irq"},  32'(xfer_irq),  32'd0);
    check({tag, ".overflow"},  32'(overflow),  32'd0);
    check({tag, ".underflow"}, 32'(underflow), 32'd0);
`ifdef ACQBUF_OVF_CNT_EN
    check({tag, ".ovf_cnt"},   32'(ovf_cnt),   32'd0);
`endif
  endtask

  // Asynchronous reset pulse, outputs checked before any clock edge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    check_idle(tag);
    reset = 1'b0;
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic write_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_en  = 1'b1;
      datain = 16'(base + i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic read_check(input int n, input int base, input string tag);
    for (int i = 0; i < n; i++) begin
      rd_strobe = 1'b1;
      tick();
      check(tag, 32'(dataout), 32'(base + i));
    end
    rd_strobe = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    clr       = 1'b0;
    wr_en     = 1'b0;
    rd_strobe = 1'b0;
    datain    = 16'h0000;
    #1;

    // Reset state
    do_reset("rst0");

    // Burst of 256 words raises the request one cycle after count reaches 256
    write_n(256, 0);
    check("s1.count256", 32'(count),    32'd256);
    check("s1.irq_pre",  32'(xfer_irq), 32'd0);
    tick();
    check("s1.irq_up",   32'(xfer_irq), 32'd1);
    rd_strobe = 1'b1;
    tick();
    check("s1.rd0",      32'(dataout),  32'h0000);
    check("s1.irq_xfer", 32'(xfer_irq), 32'd0);
    read_check(255, 1, "s1.rd");
    check("s1.count0",   32'(count),    32'd0);
    check("s1.empty",    32'(empty),    32'd1);
    tick();
    tick();
    check("s1.irq_arm",  32'(xfer_irq), 32'd0);

    // Fill to full, one dropped word, full-cycle read+write drops the write
    do_reset("rst1");
    write_n(512, 16'h1000);
    check("s2.full",     32'(full),     32'd1);
    check("s2.count512", 32'(count),    32'd512);
    check("s2.ovf_pre",  32'(overflow), 32'd0);
    write_n(1, 16'h1200);
    check("s2.count_drop", 32'(count),  32'd512);
    check("s2.ovf",      32'(overflow), 32'd1);
`ifdef ACQBUF_OVF_CNT_EN
    check("s2.ovf_cnt1", 32'(ovf_cnt),  32'd1);
`endif
    wr_en     = 1'b1;
    rd_strobe = 1'b1;
    datain    = 16'h7777;
    tick();
    wr_en     = 1'b0;
    rd_strobe = 1'b0;
    check("s2.rw_full_count", 32'(count),   32'd511);
    check("s2.rw_full_data",  32'(dataout), 32'h1000);
    check("s2.rw_full_notfull", 32'(full),  32'd0);
`ifdef ACQBUF_OVF_CNT_EN
    check("s2.ovf_cnt2", 32'(ovf_cnt),  32'd2);
`endif
    read_check(511, 16'h1001, "s2.rd");
    check("s2.empty",    32'(empty),    32'd1);
    check("s2.ovf_sticky", 32'(overflow), 32'd1);
    do_clr();
    check_idle("s2.clr");

    // Read while empty holds dataout and flags underflow
    write_n(1, 16'hABCD);
    read_check(1, 16'hABCD, "s3.rd");
    check("s3.unf_pre",  32'(underflow), 32'd0);
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    check("s3.unf",      32'(underflow), 32'd1);
    check("s3.hold",     32'(dataout),   32'hABCD);
    check("s3.count",    32'(count),     32'd0);

    // Steady state at count=100 with simultaneous write and read
    do_clr();
    check("s4.unf_clr",  32'(underflow), 32'd0);
    write_n(100, 16'h2000);
    for (int i = 0; i < 50; i++) begin
      wr_en     = 1'b1;
      rd_strobe = 1'b1;
      datain    = 16'(16'h2000 + 100 + i);
      tick();
      check("s4.rw_data",  32'(dataout), 32'(16'h2000 + i));
      check("s4.rw_count", 32'(count),   32'd100);
    end
    wr_en     = 1'b0;
    rd_strobe = 1'b0;
    read_check(100, 16'h2032, "s4.rd");

    // Reset mid-XFER at count=300, burst=120
    do_reset("rst5");
    write_n(436, 16'h3000);
    check("s5.count436", 32'(count),    32'd436);
    check("s5.irq_req",  32'(xfer_irq), 32'd1);
    read_check(136, 16'h3000, "s5.rd");
    check("s5.count300", 32'(count),    32'd300);
    check("s5.irq_xfer", 32'(xfer_irq), 32'd0);
    do_reset("s5.rst");
    tick();
    check("s5.irq_after_rst", 32'(xfer_irq), 32'd0);
    check("s5.count_after_rst", 32'(count), 32'd0);

    // Same scenario with soft clear, overriding same-cycle write and read
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    check("s5c.unf",     32'(underflow), 32'd1);
    write_n(436, 16'h3000);
    read_check(136, 16'h3000, "s5c.rd");
    check("s5c.count300", 32'(count),   32'd300);
    clr       = 1'b1;
    wr_en     = 1'b1;
    rd_strobe = 1'b1;
    datain    = 16'h5555;
    tick();
    clr       = 1'b0;
    wr_en     = 1'b0;
    rd_strobe = 1'b0;
    check_idle("s5c.clr");
    tick();
    check("s5c.count_hold", 32'(count), 32'd0);

    // Burst completes with count still at THRESH: request re-raised
    do_reset("rst6");
    write_n(600, 16'h4000);
    check("s6.count",    32'(count),    32'd512);
    check("s6.ovf",      32'(overflow), 32'd1);
`ifdef ACQBUF_OVF_CNT_EN
    check("s6.ovf_cnt88", 32'(ovf_cnt), 32'd88);
`endif
    read_check(256, 16'h4000, "s6.rd");
    check("s6.count256", 32'(count),    32'd256);
    check("s6.irq_arm",  32'(xfer_irq), 32'd0);
    tick();
    check("s6.irq_rereq", 32'(xfer_irq), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
